pc_fetch_unit: RTL
==================

# pc_fetch_unit

Program-counter and instruction-fetch stage of the single-cycle MIPS datapath. Holds the PC, fetches instruction words from instruction memory over a request/valid handshake, and presents each instruction for exactly one execute cycle. During that cycle it consumes the 32-bit sign-extended immediate produced by the sign-extension stage and computes the next PC: sequential, branch, or jump.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  holds the current instruction and PC in the execute cycle.
- branch_taken  in  1  branch resolved taken; sampled only in EXEC.
- imm_sign  in  32  sign-extended immediate from the sign-extension stage.
- jump  in  1  unconditional jump; sampled only in EXEC.
- jump_target  in  32  absolute jump address.
- imem_req  out  1  fetch request, equal to (state == FETCH).
- imem_addr  out  32  fetch address, always equal to pc_out.
- imem_rvalid  in  1  memory data valid; sampled only in FETCH.
- imem_rdata  in  32  instruction word.
- instr  out  32  latched instruction.
- instr_valid  out  1  high exactly while state == EXEC.
- pc_out  out  32  current PC.
- pc_plus4  out  32  pc_out + 4, combinational.
- misalign_err  out  1  sticky error flag; present only with MISALIGN_TRAP_EN.

## Operation
- States: IDLE, FETCH, EXEC, plus HALT when MISALIGN_TRAP_EN is defined.
- IDLE always goes to FETCH on the next cycle.
- FETCH: imem_req = 1.
  - If imem_rvalid: instr <= imem_rdata and go to EXEC.
  - Otherwise stay in FETCH with the address held stable.
- EXEC: instr_valid = 1.
  - If stall: stay in EXEC; PC and instr unchanged; branch and jump ignored.
  - Otherwise update PC and go to FETCH.
- Next-PC priority:
  - jump: next PC = jump_target.
  - else branch_taken: next PC = pc + 4 + (imm_sign << 2).
  - else: next PC = pc + 4.
- Arithmetic is 32-bit, modulo 2^32. Wrap-around is silent: pc = 32'hFFFF_FFFC with no branch/jump gives next PC 0.
- imm_sign << 2 drops the top two bits; no overflow detection.
- jump and branch_taken asserted together: jump wins.
- imem_rvalid outside FETCH is ignored. instr is not overwritten.
- rst asserted mid-fetch or mid-execute:
  - State goes to IDLE immediately.
  - Any outstanding memory response is discarded, because IDLE ignores rvalid.

## Timing
- Reset values:
  - pc_out = RESET_PC
  - instr = 0
  - state = IDLE, so instr_valid = 0 and imem_req = 0
  - misalign_err = 0
- First imem_req is asserted in the second cycle after rst deasserts (one cycle in IDLE).
- Zero-wait memory (rvalid in the same cycle as req): one FETCH cycle plus one EXEC cycle, i.e. 2 cycles per instruction.
- Each cycle of memory wait adds one cycle in FETCH.
- The PC register updates on the clock edge that leaves EXEC. The new imem_addr is visible in the following FETCH cycle.
- pc_plus4 and the target adder are combinational from pc_out and imm_sign. Inputs must be stable in EXEC before the edge.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A jump in EXEC with jump_target[1:0] != 0 sets misalign_err.
  - PC is not updated and the FSM enters HALT.
  - HALT is exited only by rst. imem_req = 0 and instr_valid = 0 in HALT.
- MISALIGN_TRAP_EN undefined:
  - jump_target[1:0] are forced to 0.
  - There is no HALT state.
  - The misalign_err port is absent.
- Branch targets are always aligned, so the macro does not affect branches.

## Structure
- Shared package mips_pkg holds:
  - the fetch-state enum (IDLE, FETCH, EXEC, HALT)
  - the PC width constant (32)
  - the PC increment constant (4)
- One sub-module: pc_next_calc, purely combinational.
  - Inputs: pc, imm_sign, jump, jump_target, branch_taken.
  - Output: the next PC, applying the priority and alignment rules.
- The top level holds the FSM, the PC register and the instruction register.

## Test plan
- Reset: RESET_PC = 32'h0000_0040, release rst, memory answers in the same cycle.
  - imem_req rises in the 2nd cycle with imem_addr = 0x40.
  - instr_valid pulses in the 3rd cycle.
  - Next fetch address is 0x44.
- Branch: pc = 0x100, imm_sign = 32'hFFFF_FFFE, branch_taken = 1 in EXEC.
  - Next imem_addr = 0x100 + 4 - 8 = 0xFC.
- Priority: jump = 1 with jump_target = 0x2000 and branch_taken = 1 at the same time.
  - Next PC = 0x2000.
- Wait states and stall:
  - rvalid delayed 3 cycles: imem_req held for 4 cycles with imem_addr stable; instr latched only on the rvalid cycle.
  - stall held 2 cycles in EXEC: instr_valid high for 3 cycles; PC unchanged until stall drops.
- Wrap and mid-fetch reset:
  - pc = 0xFFFF_FFFC, sequential: next PC = 0.
  - rst asserted during FETCH: immediate return to IDLE and pc = RESET_PC; a late rvalid does not change instr.
- With MISALIGN_TRAP_EN: jump_target = 0x2002.
  - misalign_err = 1 and PC held.
  - imem_req stays 0 until rst.
  - Without the macro, next PC = 0x2000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch stage.
// The HALT state is only reachable when MISALIGN_TRAP_EN is defined.
package mips_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: jump over taken branch over sequential.
// Without MISALIGN_TRAP_EN the low two jump-target bits are cleared here.
module pc_next_calc
  import mips_pkg::*;
(
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-1:0] imm_sign_i,
  input  logic            jump_i,
  input  logic [PC_W-1:0] jump_target_i,
  input  logic            branch_taken_i,
  output logic [PC_W-1:0] next_pc_o
);

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] br_pc;
  logic [PC_W-1:0] jmp_pc;

  assign seq_pc = pc_i + PC_INC;
  // Shifting out the top immediate bits is intentional; the sum wraps silently.
  assign br_pc  = seq_pc + (imm_sign_i << 2);

`ifdef MISALIGN_TRAP_EN
  assign jmp_pc = jump_target_i;
`else
  assign jmp_pc = jump_target_i & ~32'h0000_0003;
`endif

  always_comb begin
    next_pc_o = seq_pc;
    if (jump_i) begin
      next_pc_o = jmp_pc;
    end else if (branch_taken_i) begin
      next_pc_o = br_pc;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, instruction register and IDLE/FETCH/EXEC fetch FSM.
// Define MISALIGN_TRAP_EN to trap misaligned jumps into HALT with misalign_err.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] imm_sign,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_err
`endif
);

  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [31:0]     instr_q;

  pc_next_calc u_next (
    .pc_i          (pc_q),
    .imm_sign_i    (imm_sign),
    .jump_i        (jump),
    .jump_target_i (jump_target),
    .branch_taken_i(branch_taken),
    .next_pc_o     (pc_d)
  );

`ifdef MISALIGN_TRAP_EN
  logic err_q;
  logic jump_misaligned;

  assign jump_misaligned = jump && (jump_target[1:0] != 2'b00);
  assign misalign_err    = err_q;
`endif

  // Memory responses are only honoured in FETCH, so reset or a late rvalid never corrupts instr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: state_q <= FETCH;
        FETCH: begin
          if (imem_rvalid) begin
            instr_q <= imem_rdata;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
`ifdef MISALIGN_TRAP_EN
            if (jump_misaligned) begin
              err_q   <= 1'b1;
              state_q <= HALT;
            end else begin
              pc_q    <= pc_d;
              state_q <= FETCH;
            end
`else
            pc_q    <= pc_d;
            state_q <= FETCH;
`endif
          end
        end
`ifdef MISALIGN_TRAP_EN
        HALT: state_q <= HALT;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign instr_valid = (state_q == EXEC);
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign pc_plus4    = pc_q + PC_INC;
  assign instr       = instr_q;

endmodule
